// File: rtl/scratchpad_memory_stage3_pkg.sv
// Shared scratchpad-memory types and sizes for the read-return stage.
package scratchpad_memory_stage3_pkg;

  localparam int SM_PROCESSING_ELEMENTS = 16;
  localparam int SM_MEMORY_BANKS        = 16;
  localparam int SM_BYTE_PER_ENTRY      = 4;
  localparam int SM_PIGGYBACK_DATA_LEN  = 8;

  typedef logic [SM_BYTE_PER_ENTRY*8-1:0]        sm_data_t;
  typedef logic [$clog2(SM_MEMORY_BANKS)-1:0]    sm_bank_address_t;
  typedef logic [SM_BYTE_PER_ENTRY-1:0]          sm_byte_mask_t;
  typedef logic [SM_PIGGYBACK_DATA_LEN-1:0]      sm_piggyback_t;

  // acc is empty in IDLE and holds earlier passes' lanes in COLLECT
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } sm3_state_t;

endpackage

// File: rtl/scratchpad_memory_stage3_if.sv
// Pass input bundle from stage 2 and result bundle to the consumer.
interface scratchpad_memory_stage3_if;
  import scratchpad_memory_stage3_pkg::*;

  logic                                          sm2_is_last_request;
  sm_bank_address_t [SM_PROCESSING_ELEMENTS-1:0] sm2_bank_indexes;
  sm_data_t         [SM_MEMORY_BANKS-1:0]        sm2_read_data;
  logic             [SM_PROCESSING_ELEMENTS-1:0] sm2_satisfied_mask;
  sm_byte_mask_t    [SM_PROCESSING_ELEMENTS-1:0] sm2_byte_mask;
  logic             [SM_PROCESSING_ELEMENTS-1:0] sm2_mask;
  sm_piggyback_t                                 sm2_piggyback_data;

  logic                                          sm3_valid;
  sm_data_t         [SM_PROCESSING_ELEMENTS-1:0] sm3_read_data;
  logic             [SM_PROCESSING_ELEMENTS-1:0] sm3_mask;
  sm_piggyback_t                                 sm3_piggyback_data;
  logic                                          sm3_collecting;

  modport master (
    output sm2_is_last_request, sm2_bank_indexes, sm2_read_data,
           sm2_satisfied_mask, sm2_byte_mask, sm2_mask, sm2_piggyback_data,
    input  sm3_valid, sm3_read_data, sm3_mask, sm3_piggyback_data,
           sm3_collecting
  );

  modport slave (
    input  sm2_is_last_request, sm2_bank_indexes, sm2_read_data,
           sm2_satisfied_mask, sm2_byte_mask, sm2_mask, sm2_piggyback_data,
    output sm3_valid, sm3_read_data, sm3_mask, sm3_piggyback_data,
           sm3_collecting
  );

endinterface

// File: rtl/scratchpad_memory_stage3_output_interconnect.sv
// Combinational bank-to-PE crossbar with per-byte enable masking.
module output_interconnect
  import scratchpad_memory_stage3_pkg::*;
(
  input  sm_data_t         [SM_MEMORY_BANKS-1:0]        bank_data_i,
  input  sm_bank_address_t [SM_PROCESSING_ELEMENTS-1:0] bank_idx_i,
  input  sm_byte_mask_t    [SM_PROCESSING_ELEMENTS-1:0] byte_mask_i,
  output sm_data_t         [SM_PROCESSING_ELEMENTS-1:0] routed_o
);

  // each lane picks its bank word, then drops disabled bytes to zero
  for (genvar g = 0; g < SM_PROCESSING_ELEMENTS; g++) begin : g_lane
    sm_data_t sel;
    assign sel = bank_data_i[bank_idx_i[g]];
    for (genvar b = 0; b < SM_BYTE_PER_ENTRY; b++) begin : g_byte
      assign routed_o[g][b*8 +: 8] = byte_mask_i[g][b] ? sel[b*8 +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/scratchpad_memory_stage3.sv
// Read-return stage: routes bank words to PEs, gathers multi-pass
// instructions in a collector and publishes the result for one cycle.
module scratchpad_memory_stage3
  import scratchpad_memory_stage3_pkg::*;
(
  input  logic                        clock,
  input  logic                        resetn,
  scratchpad_memory_stage3_if.slave   bus
);

  localparam int PE = SM_PROCESSING_ELEMENTS;

  sm3_state_t         state_q, state_d;
  sm_data_t [PE-1:0]  acc_q, acc_d;
  sm_data_t [PE-1:0]  rd_q, rd_d;
  logic     [PE-1:0]  mask_q, mask_d;
  sm_piggyback_t      pb_q, pb_d;
  logic               valid_q, valid_d;
  logic               coll_q, coll_d;

  sm_data_t [PE-1:0]  routed;
  sm_data_t [PE-1:0]  merged;
  logic               pv;

  output_interconnect u_xbar (
    .bank_data_i (bus.sm2_read_data),
    .bank_idx_i  (bus.sm2_bank_indexes),
    .byte_mask_i (bus.sm2_byte_mask),
    .routed_o    (routed)
  );

  assign pv = |bus.sm2_satisfied_mask;

  // overlay this pass's lanes on the collector; IDLE starts from zero
  always_comb begin
    merged = '0;
    for (int p = 0; p < PE; p++) begin
      if (bus.sm2_satisfied_mask[p])  merged[p] = routed[p];
      else if (state_q == COLLECT)    merged[p] = acc_q[p];
      else                            merged[p] = '0;
    end
  end

  // next-state: collect on non-last passes, publish and clear on the last
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    pb_d    = pb_q;
    valid_d = 1'b0;
    if (pv) begin
      if (bus.sm2_is_last_request) begin
        rd_d    = merged;
        mask_d  = bus.sm2_mask;
        pb_d    = bus.sm2_piggyback_data;
        acc_d   = '0;
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        acc_d   = merged;
        state_d = COLLECT;
      end
    end
    coll_d = (state_d == COLLECT);
  end

  // state, collector and output registers; reset drops any partial gather
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rd_q    <= '0;
      mask_q  <= '0;
      pb_q    <= '0;
      valid_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      pb_q    <= pb_d;
      valid_q <= valid_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.sm3_valid          = valid_q;
  assign bus.sm3_read_data      = rd_q;
  assign bus.sm3_mask           = mask_q;
  assign bus.sm3_piggyback_data = pb_q;
  assign bus.sm3_collecting     = coll_q;

endmodule

// File: tb/tb_scratchpad_memory_stage3.sv
// Directed vector bench for the scratchpad read-return stage.
module tb_scratchpad_memory_stage3;
  import scratchpad_memory_stage3_pkg::*;

  localparam int PE = SM_PROCESSING_ELEMENTS;
  localparam int NB = SM_MEMORY_BANKS;

  typedef struct {
    logic                          last;
    logic [PE-1:0]                 sat;
    logic [PE-1:0]                 mask;
    sm_piggyback_t                 pb;
    sm_bank_address_t [PE-1:0]     idx;
    sm_byte_mask_t    [PE-1:0]     bm;
    sm_data_t         [NB-1:0]     bank;
    logic                          exp_valid;
    logic                          exp_coll;
    sm_data_t         [PE-1:0]     exp_rd;
    logic [PE-1:0]                 exp_mask;
    sm_piggyback_t                 exp_pb;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  scratchpad_memory_stage3_if bus();

  scratchpad_memory_stage3 dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // a lane served twice inside one instruction is a protocol violation
  logic [PE-1:0] seen;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) seen <= '0;
    else if (|bus.sm2_satisfied_mask) begin
      assert ((bus.sm2_satisfied_mask & seen) == '0)
        else $error("lane served twice in one instruction: %h", bus.sm2_satisfied_mask & seen);
      seen <= bus.sm2_is_last_request ? '0 : (seen | bus.sm2_satisfied_mask);
    end
  end

  task automatic drive(input vec_t v);
    bus.sm2_is_last_request = v.last;
    bus.sm2_satisfied_mask  = v.sat;
    bus.sm2_mask            = v.mask;
    bus.sm2_piggyback_data  = v.pb;
    bus.sm2_bank_indexes    = v.idx;
    bus.sm2_byte_mask       = v.bm;
    bus.sm2_read_data       = v.bank;
  endtask

  task automatic check(input string name, input logic ev, input logic ec,
                       input sm_data_t [PE-1:0] erd, input logic [PE-1:0] em,
                       input sm_piggyback_t epb);
    checks += 5;
    if (bus.sm3_valid !== ev) begin
      errors++; $display("FAIL %s valid got %b want %b", name, bus.sm3_valid, ev);
    end
    if (bus.sm3_collecting !== ec) begin
      errors++; $display("FAIL %s collecting got %b want %b", name, bus.sm3_collecting, ec);
    end
    if (bus.sm3_read_data !== erd) begin
      errors++; $display("FAIL %s read_data got %h want %h", name, bus.sm3_read_data, erd);
    end
    if (bus.sm3_mask !== em) begin
      errors++; $display("FAIL %s mask got %h want %h", name, bus.sm3_mask, em);
    end
    if (bus.sm3_piggyback_data !== epb) begin
      errors++; $display("FAIL %s piggyback got %h want %h", name, bus.sm3_piggyback_data, epb);
    end
  endtask

  // blank pass: no lane satisfied, identity indexes, full byte enables
  function automatic vec_t blank();
    vec_t v;
    v.last = 1'b0; v.sat = '0; v.mask = '0; v.pb = '0;
    v.exp_valid = 1'b0; v.exp_coll = 1'b0; v.exp_rd = '0;
    v.exp_mask = '0; v.exp_pb = '0;
    for (int p = 0; p < PE; p++) begin
      v.idx[p] = sm_bank_address_t'(p);
      v.bm[p]  = 4'hF;
    end
    v.bank = '0;
    return v;
  endfunction

  vec_t vecs[5];
  vec_t v;
  sm_data_t [PE-1:0] held;
  sm_data_t [PE-1:0] zero_rd;

  initial begin
    zero_rd = '0;
    // 0: single pass, reversed routing
    vecs[0] = blank();
    vecs[0].last = 1'b1; vecs[0].sat = 16'hFFFF; vecs[0].mask = 16'hFFFF; vecs[0].pb = 8'h5A;
    for (int k = 0; k < NB; k++) vecs[0].bank[k] = 32'h1000 + k;
    for (int p = 0; p < PE; p++) begin
      vecs[0].idx[p] = sm_bank_address_t'(15 - p);
      vecs[0].exp_rd[p] = 32'h1000 + 15 - p;
    end
    vecs[0].exp_valid = 1'b1; vecs[0].exp_mask = 16'hFFFF; vecs[0].exp_pb = 8'h5A;
    // 1: first pass of a two-pass conflict, outputs hold previous result
    vecs[1] = blank();
    vecs[1].sat = 16'h00FF; vecs[1].mask = 16'hFFFF; vecs[1].pb = 8'h33;
    for (int k = 0; k < NB; k++) vecs[1].bank[k] = 32'h2000 + k;
    vecs[1].exp_coll = 1'b1; vecs[1].exp_rd = vecs[0].exp_rd;
    vecs[1].exp_mask = 16'hFFFF; vecs[1].exp_pb = 8'h5A;
    // 2: second, last pass
    vecs[2] = blank();
    vecs[2].last = 1'b1; vecs[2].sat = 16'hFF00; vecs[2].mask = 16'hFFFF; vecs[2].pb = 8'h33;
    for (int k = 0; k < NB; k++) vecs[2].bank[k] = 32'h3000 + k;
    for (int p = 0; p < PE; p++) vecs[2].exp_rd[p] = (p < 8) ? 32'h2000 + p : 32'h3000 + p;
    vecs[2].exp_valid = 1'b1; vecs[2].exp_mask = 16'hFFFF; vecs[2].exp_pb = 8'h33;
    // 3: back-to-back single pass, byte mask 0011 on lane 3 only
    vecs[3] = blank();
    vecs[3].last = 1'b1; vecs[3].sat = 16'h0008; vecs[3].mask = 16'h0008; vecs[3].pb = 8'h11;
    vecs[3].bank[2] = 32'hAABBCCDD; vecs[3].idx[3] = 4'd2; vecs[3].bm[3] = 4'b0011;
    vecs[3].exp_rd[3] = 32'h0000CCDD;
    vecs[3].exp_valid = 1'b1; vecs[3].exp_mask = 16'h0008; vecs[3].exp_pb = 8'h11;
    // 4: every byte-mask pattern, all lanes on bank 0
    vecs[4] = blank();
    vecs[4].last = 1'b1; vecs[4].sat = 16'hFFFF; vecs[4].mask = 16'hFFFF; vecs[4].pb = 8'h44;
    vecs[4].bank[0] = 32'hAABBCCDD;
    for (int p = 0; p < PE; p++) begin
      vecs[4].idx[p] = '0;
      vecs[4].bm[p]  = sm_byte_mask_t'(p);
      vecs[4].exp_rd[p] = 32'hAABBCCDD &
        {{8{p[3]}}, {8{p[2]}}, {8{p[1]}}, {8{p[0]}}};
    end
    vecs[4].exp_valid = 1'b1; vecs[4].exp_mask = 16'hFFFF; vecs[4].exp_pb = 8'h44;

    drive(blank());
    #12;
    check("reset", 1'b0, 1'b0, zero_rd, '0, '0);
    @(negedge clock) resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clock) drive(vecs[i]);
      @(posedge clock) #1;
      check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_coll,
            vecs[i].exp_rd, vecs[i].exp_mask, vecs[i].exp_pb);
    end

    // idle pass with last=1 mid-collection must be ignored
    v = blank();
    v.sat = 16'h000F; v.mask = 16'h00FF; v.pb = 8'h66;
    for (int k = 0; k < NB; k++) v.bank[k] = 32'h5000 + k;
    @(negedge clock) drive(v);
    @(posedge clock) #1;
    check("idle_p1", 1'b0, 1'b1, vecs[4].exp_rd, 16'hFFFF, 8'h44);
    v = blank();
    v.last = 1'b1; v.mask = 16'hFFFF; v.pb = 8'hEE;
    for (int k = 0; k < NB; k++) v.bank[k] = 32'hFFFFFFFF;
    @(negedge clock) drive(v);
    @(posedge clock) #1;
    check("idle_gap", 1'b0, 1'b1, vecs[4].exp_rd, 16'hFFFF, 8'h44);
    v = blank();
    v.last = 1'b1; v.sat = 16'h00F0; v.mask = 16'h00FF; v.pb = 8'h77;
    for (int k = 0; k < NB; k++) v.bank[k] = 32'h6000 + k;
    @(negedge clock) drive(v);
    @(posedge clock) #1;
    held = '0;
    for (int p = 0; p < 4; p++) held[p] = 32'h5000 + p;
    for (int p = 4; p < 8; p++) held[p] = 32'h6000 + p;
    check("idle_p2", 1'b1, 1'b0, held, 16'h00FF, 8'h77);
    @(negedge clock) drive(blank());
    @(posedge clock) #1;
    check("pulse_end", 1'b0, 1'b0, held, 16'h00FF, 8'h77);

    // asynchronous reset in the middle of a two-pass instruction
    v = blank();
    v.sat = 16'hFF00; v.mask = 16'hFFFF; v.pb = 8'h99;
    for (int k = 0; k < NB; k++) v.bank[k] = 32'hDEAD0000 + k;
    @(negedge clock) drive(v);
    @(posedge clock) #1;
    check("rst_p1", 1'b0, 1'b1, held, 16'h00FF, 8'h77);
    #2 resetn = 1'b0;
    #1 check("rst_async", 1'b0, 1'b0, zero_rd, '0, '0);
    @(negedge clock) begin resetn = 1'b1; drive(blank()); end
    @(posedge clock) #1;
    check("rst_idle", 1'b0, 1'b0, zero_rd, '0, '0);
    v = blank();
    v.last = 1'b1; v.sat = 16'h000F; v.mask = 16'h000F; v.pb = 8'h22;
    for (int k = 0; k < NB; k++) v.bank[k] = 32'h4000 + k;
    @(negedge clock) drive(v);
    @(posedge clock) #1;
    held = '0;
    for (int p = 0; p < 4; p++) held[p] = 32'h4000 + p;
    check("rst_after", 1'b1, 1'b0, held, 16'h000F, 8'h22);

    @(negedge clock) drive(blank());
    @(posedge clock) #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
